pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Hazard and stall controller for the 5-stage pipeline (F, D, X, M, W with latches FD, DX, XM, MW, WB). It computes operand-forwarding selects for the instruction in X, including the WB forwarding register. It sequences load-use bubbles, data-memory wait freezes and taken-branch flushes by driving per-latch enables and bubble/flush strobes. It also counts stall cycles and flags memory-wait timeouts.

## Interface
- MAX_WAIT, 64: data-memory wait cycles allowed before timeout (≥1)
- CNT_W, 32: stall performance counter width

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- DX_rs1, DX_rs2  in  5  source registers of the instruction in X
- DX_use_rs1, DX_use_rs2  in  1  X instruction reads rs1 / rs2
- XM_rd  in  5, XM_wer  in  1, XM_is_load  in  1  instruction in M
- XM_mem_op  in  1  M instruction accesses data memory
- MW_rd  in  5, MW_wer  in  1  instruction in W
- WB_rd  in  5, WB_wer  in  1  WB forwarding register contents
- dmem_ready  in  1  data memory completes the access this cycle
- X_branch_taken  in  1  X resolved a taken branch or jump
- fwd_a, fwd_b  out  2  operand select: 0 regfile, 1 XM, 2 MW, 3 WB
- pc_en, fd_en, dx_en, xm_en, mw_en, wb_en  out  1  latch enables
- xm_bubble  out  1  load NOP into XM instead of DX
- fd_flush, dx_flush  out  1  load NOP into FD / DX
- stall_cnt  out  CNT_W  cycles with pc_en low
- mem_timeout  out  1  sticky error

## Operation
- Forwarding is combinational. For each operand, when its use bit is set and rs≠0, select the first match in priority order:
  - XM, if XM_wer and XM_rd==rs
  - MW, if MW_wer and MW_rd==rs
  - WB, if WB_wer and WB_rd==rs
  - otherwise regfile.
- Register x0 is never forwarded.
- Load-use hazard (lu): XM_is_load, XM_wer, XM_rd≠0, and XM_rd matches a used rs of the X instruction.
- FSM states:
  - RUN
  - MEM_WAIT
  - TIMEOUT
- RUN → MEM_WAIT when XM_mem_op and !dmem_ready. MEM_WAIT → RUN on the first cycle dmem_ready=1. MEM_WAIT → TIMEOUT when the wait counter reaches MAX_WAIT. TIMEOUT is left only by reset.
- Action priority, one action per cycle:
  1. Freeze: applies when the state is TIMEOUT, or when XM_mem_op and !dmem_ready. All enables are 0. No bubble, no flush.
  2. Load-use: pc_en, fd_en and dx_en are 0. xm_en, mw_en, wb_en and xm_bubble are 1.
  3. Branch: all enables are 1. fd_flush and dx_flush are 1.
  4. Normal: all enables are 1. All strobes are 0.
- A taken branch coinciding with freeze or load-use is ignored that cycle. X holds the branch, so it is re-presented.
- The wait counter is 0 in RUN and increments each freeze cycle in MEM_WAIT. mem_timeout is set on entry to TIMEOUT.
- stall_cnt increments, saturating at all-ones, on every cycle with pc_en=0.

## Timing
- Reset values:
  - FSM in RUN
  - wait counter 0
  - stall_cnt 0
  - mem_timeout 0
  - combinational outputs follow inputs with the FSM in RUN.
- Enables, strobes and fwd_* are combinational from the current inputs and state. There is no added latency.
- A load-use stall lasts exactly 1 cycle. The next cycle XM holds a bubble (XM_wer=0), the load is in MW, and fwd_* select MW.
- A memory wait of N cycles with dmem_ready=0 freezes for N cycles. Advance happens in the cycle dmem_ready=1.
- With MAX_WAIT=M, M consecutive not-ready cycles in MEM_WAIT enter TIMEOUT on the next edge. mem_timeout rises in that same edge.
- Asserting rst_n low mid-stall returns all state to reset values immediately, asynchronously.

## Test plan
- Forwarding priority: DX_rs1=5, with XM, MW and WB all writing x5 → fwd_a=1. Drop XM_wer → 2. Drop MW_wer → 3. Set rs1=0 → 0.
- Load-use: XM_is_load, XM_rd=7, DX_rs2=7 used → one cycle with pc_en=fd_en=dx_en=0 and xm_bubble=1. Next cycle, bubble in XM and MW_rd=7 → fwd_b=2 with no stall. stall_cnt=1.
- Memory wait: XM_mem_op with dmem_ready low for 3 cycles → all enables 0 for 3 cycles, then advance on the ready cycle. stall_cnt=3 and the FSM is back in RUN.
- Timeout with MAX_WAIT=4: dmem_ready held low → TIMEOUT and mem_timeout=1. Enables stay 0 even after dmem_ready=1, until rst_n is pulsed.
- Branch: X_branch_taken alone → fd_flush=dx_flush=1 with enables 1. Branch plus a load-use in the same cycle → load-use action only. Branch re-presented next cycle → flush.
- Asynchronous reset mid-MEM_WAIT: rst_n low between edges → stall_cnt=0, mem_timeout=0 and the FSM in RUN without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for a 5-stage pipeline: operand forwarding selects,
// load-use bubbles, data-memory wait freezes, branch flushes and stall counting.
//
// state    | meaning
// RUN      | pipeline advancing normally (load-use and branch actions allowed)
// MEM_WAIT | data memory access outstanding, wait counter running
// TIMEOUT  | memory never answered; pipeline frozen until reset
module pipe_hazard_ctrl #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       DX_rs1,
  input  logic [4:0]       DX_rs2,
  input  logic             DX_use_rs1,
  input  logic             DX_use_rs2,
  input  logic [4:0]       XM_rd,
  input  logic             XM_wer,
  input  logic             XM_is_load,
  input  logic             XM_mem_op,
  input  logic [4:0]       MW_rd,
  input  logic             MW_wer,
  input  logic [4:0]       WB_rd,
  input  logic             WB_wer,
  input  logic             dmem_ready,
  input  logic             X_branch_taken,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             pc_en,
  output logic             fd_en,
  output logic             dx_en,
  output logic             xm_en,
  output logic             mw_en,
  output logic             wb_en,
  output logic             xm_bubble,
  output logic             fd_flush,
  output logic             dx_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             mem_timeout
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, TIMEOUT} state_t;

  state_t              state, state_nx;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nx;
  logic                mem_stall, freeze, load_use;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs, input logic use_rs,
    input logic [4:0] xm_rd, input logic xm_wer,
    input logic [4:0] mw_rd, input logic mw_wer,
    input logic [4:0] wb_rd, input logic wb_wer);
    logic [1:0] sel;
    sel = 2'd0;
    if (use_rs && rs != 5'd0) begin
      if (xm_wer && xm_rd == rs)      sel = 2'd1;
      else if (mw_wer && mw_rd == rs) sel = 2'd2;
      else if (wb_wer && wb_rd == rs) sel = 2'd3;
    end
    return sel;
  endfunction

  assign fwd_a = fwd_sel(DX_rs1, DX_use_rs1, XM_rd, XM_wer, MW_rd, MW_wer, WB_rd, WB_wer);
  assign fwd_b = fwd_sel(DX_rs2, DX_use_rs2, XM_rd, XM_wer, MW_rd, MW_wer, WB_rd, WB_wer);

  assign mem_stall = XM_mem_op && !dmem_ready;
  assign freeze    = (state == TIMEOUT) || mem_stall;
  assign load_use  = XM_is_load && XM_wer && (XM_rd != 5'd0) &&
                     ((DX_use_rs1 && DX_rs1 == XM_rd) || (DX_use_rs2 && DX_rs2 == XM_rd));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      stall_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (!pc_en && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (state_nx == TIMEOUT)
        mem_timeout <= 1'b1;
    end
  end

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = '0;
    pc_en       = 1'b1;
    fd_en       = 1'b1;
    dx_en       = 1'b1;
    xm_en       = 1'b1;
    mw_en       = 1'b1;
    wb_en       = 1'b1;
    xm_bubble   = 1'b0;
    fd_flush    = 1'b0;
    dx_flush    = 1'b0;

    case (state)
      RUN:      if (mem_stall) state_nx = MEM_WAIT;
      MEM_WAIT: begin
        // wait_cnt counts not-ready cycles already spent in MEM_WAIT
        if (!mem_stall)
          state_nx = RUN;
        else if (wait_cnt == WAIT_W'(MAX_WAIT - 1))
          state_nx = TIMEOUT;
        else
          wait_cnt_nx = wait_cnt + 1'b1;
      end
      TIMEOUT:  state_nx = TIMEOUT;
      default:  state_nx = RUN;
    endcase

    if (freeze) begin
      {pc_en, fd_en, dx_en, xm_en, mw_en, wb_en} = 6'b000000;
    end else if (load_use) begin
      {pc_en, fd_en, dx_en} = 3'b000;
      xm_bubble = 1'b1;
    end else if (X_branch_taken) begin
      fd_flush = 1'b1;
      dx_flush = 1'b1;
    end
  end

endmodule
